// File: rtl/huffman_ctrl_pkg.sv
// Shared constants for the Huffman pipeline controller: FSM encoding, stage IDs and defaults.
package huffman_ctrl_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 200000;

    typedef logic [1:0] stage_t;

    localparam stage_t STG_HIST = 2'd0;
    localparam stage_t STG_CSG  = 2'd1;
    localparam stage_t STG_CWG  = 2'd2;
    localparam stage_t STG_ENC  = 2'd3;

    // Each GO is followed by its WAIT, and each WAIT by the next GO (or FIN),
    // so the successor state is always the current encoding plus one.
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_HIST_GO   = 4'd1;
    localparam logic [3:0] ST_HIST_WAIT = 4'd2;
    localparam logic [3:0] ST_CSG_GO    = 4'd3;
    localparam logic [3:0] ST_CSG_WAIT  = 4'd4;
    localparam logic [3:0] ST_CWG_GO    = 4'd5;
    localparam logic [3:0] ST_CWG_WAIT  = 4'd6;
    localparam logic [3:0] ST_ENC_GO    = 4'd7;
    localparam logic [3:0] ST_ENC_WAIT  = 4'd8;
    localparam logic [3:0] ST_FIN       = 4'd9;
    localparam logic [3:0] ST_ERROR     = 4'd10;

    function automatic stage_t state_stage(input logic [3:0] st);
        case (st)
            ST_CSG_GO, ST_CSG_WAIT: state_stage = STG_CSG;
            ST_CWG_GO, ST_CWG_WAIT: state_stage = STG_CWG;
            ST_ENC_GO, ST_ENC_WAIT, ST_FIN: state_stage = STG_ENC;
            default: state_stage = STG_HIST;
        endcase
    endfunction

endpackage

// File: rtl/huffman_pipeline_controller_stage_watchdog.sv
// Per-stage watchdog: cleared on load, counts while enabled, flags the last allowed wait cycle.
import huffman_ctrl_pkg::*;

module stage_watchdog #(
    parameter int TMO_WIDTH      = 18,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TMO_WIDTH-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !expire_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/huffman_pipeline_controller.sv
// Sequencer for the canonical Huffman encoder: HIST -> CSG -> CWG -> ENC with watchdogs,
// abort handling and a cached code-table valid flag for encode-only jobs.
import huffman_ctrl_pkg::*;

module huffman_pipeline_controller #(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TMO_WIDTH      = 18,
    parameter int CNT_WIDTH      = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_start,
    input  logic                 cmd_reuse,
    input  logic                 cmd_abort,
    input  logic                 cmd_clear,
    output logic                 hist_start,
    output logic                 csg_start,
    output logic                 cwg_start,
    output logic                 enc_start,
    input  logic                 hist_done,
    input  logic                 csg_done,
    input  logic                 cwg_done,
    input  logic                 enc_done,
    output logic                 dp_abort,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_stage,
    output logic                 table_valid,
    output logic [CNT_WIDTH-1:0] job_cycles
);

    logic [3:0]           state_q, state_d;
    logic [3:0]           start_q;
    logic                 busy_q, done_q, error_q, dpab_q, dpab_d;
    logic                 tv_q, tv_d;
    stage_t               es_q, es_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, jc_q, jc_d;

    stage_t     stg;
    logic [3:0] done_vec;
    logic       stg_done, in_job, is_go, is_wait, expire;

    assign done_vec = {enc_done, cwg_done, csg_done, hist_done};
    assign stg      = state_stage(state_q);
    assign stg_done = done_vec[stg];
    assign in_job   = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign is_go    = (state_q == ST_HIST_GO) || (state_q == ST_CSG_GO)
                   || (state_q == ST_CWG_GO)  || (state_q == ST_ENC_GO);
    assign is_wait  = (state_q == ST_HIST_WAIT) || (state_q == ST_CSG_WAIT)
                   || (state_q == ST_CWG_WAIT)  || (state_q == ST_ENC_WAIT);

    stage_watchdog #(
        .TMO_WIDTH      (TMO_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .load_i   (is_go),
        .en_i     (is_wait),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        tv_d    = tv_q;
        es_d    = es_q;
        cnt_d   = cnt_q;
        jc_d    = jc_q;
        dpab_d  = 1'b0;
        if (in_job)
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    cnt_d = CNT_WIDTH'(1);
                    if (cmd_reuse && tv_q) begin
                        state_d = ST_ENC_GO;
                    end else begin
                        state_d = ST_HIST_GO;
                        tv_d    = 1'b0;
                    end
                end
            end
            ST_HIST_GO, ST_CSG_GO, ST_CWG_GO, ST_ENC_GO:
                state_d = state_q + 4'd1;
            ST_HIST_WAIT, ST_CSG_WAIT, ST_CWG_WAIT, ST_ENC_WAIT: begin
                // A done arriving on the expiry cycle still completes the stage.
                if (stg_done) begin
                    state_d = state_q + 4'd1;
                    if (state_q == ST_CWG_WAIT)
                        tv_d = 1'b1;
                    if (state_q == ST_ENC_WAIT)
                        jc_d = cnt_d;
                end else if (expire) begin
                    state_d = ST_ERROR;
                    es_d    = stg;
                    dpab_d  = 1'b1;
                    if (stg != STG_ENC)
                        tv_d = 1'b0;
                end
            end
            ST_FIN:
                state_d = ST_IDLE;
            ST_ERROR: begin
                if (cmd_clear) begin
                    state_d = ST_IDLE;
                    es_d    = STG_HIST;
                end
            end
            default:
                state_d = ST_IDLE;
        endcase
        // Abort overrides whatever the stage did this cycle.
        if (in_job && cmd_abort) begin
            state_d = ST_IDLE;
            dpab_d  = 1'b1;
            es_d    = es_q;
            jc_d    = jc_q;
            tv_d    = (stg != STG_ENC && state_q != ST_FIN) ? 1'b0 : tv_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            dpab_q  <= 1'b0;
            tv_q    <= 1'b0;
            es_q    <= STG_HIST;
            cnt_q   <= '0;
            jc_q    <= '0;
        end else begin
            state_q <= state_d;
            start_q <= {state_d == ST_ENC_GO, state_d == ST_CWG_GO,
                        state_d == ST_CSG_GO, state_d == ST_HIST_GO};
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
            done_q  <= (state_d == ST_FIN);
            error_q <= (state_d == ST_ERROR);
            dpab_q  <= dpab_d;
            tv_q    <= tv_d;
            es_q    <= es_d;
            cnt_q   <= cnt_d;
            jc_q    <= jc_d;
        end
    end

    assign hist_start  = start_q[STG_HIST];
    assign csg_start   = start_q[STG_CSG];
    assign cwg_start   = start_q[STG_CWG];
    assign enc_start   = start_q[STG_ENC];
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign dp_abort    = dpab_q;
    assign err_stage   = es_q;
    assign table_valid = tv_q;
    assign job_cycles  = jc_q;

endmodule
